idct8_1d_serial: RTL

//   8-point 1-D inverse DCT, the decode-side counterpart of the forward DCT path.

---
 rtl/idct_pkg.sv | 48 ++++
 rtl/idct_mac_lane.sv | 46 ++++
 rtl/idct8_1d_serial.sv | 88 ++++++++
 3 files changed

// File: rtl/idct_pkg.sv
// rtl/idct_pkg.sv - shared widths, FSM states, cosine table and round/saturate helper
// Shared by the 1-D IDCT lanes and the 2-D wrapper.
package idct_pkg;

  localparam int DATA_W = 12;
  localparam int COS_W  = 14;
  localparam int FRAC   = 12;
  localparam int OUT_W  = 9;
  localparam int ACC_W  = DATA_W + COS_W + 3;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_ROUND,
    ST_DRAIN
  } state_t;

  typedef logic signed [COS_W-1:0] cos_t;

  // C[k][n] = round(4096 * a(k) * cos((2n+1)k*pi/16)), row = k, column = n
  localparam cos_t COS_TAB [8][8] = '{
    '{ 14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448},
    '{ 14'sd2009,  14'sd1703,  14'sd1138,  14'sd400,  -14'sd400,  -14'sd1138, -14'sd1703, -14'sd2009},
    '{ 14'sd1892,  14'sd784,  -14'sd784,  -14'sd1892, -14'sd1892, -14'sd784,   14'sd784,   14'sd1892},
    '{ 14'sd1703, -14'sd400,  -14'sd2009, -14'sd1138,  14'sd1138,  14'sd2009,  14'sd400,  -14'sd1703},
    '{ 14'sd1448, -14'sd1448, -14'sd1448,  14'sd1448,  14'sd1448, -14'sd1448, -14'sd1448,  14'sd1448},
    '{ 14'sd1138, -14'sd2009,  14'sd400,   14'sd1703, -14'sd1703, -14'sd400,   14'sd2009, -14'sd1138},
    '{ 14'sd784,  -14'sd1892,  14'sd1892, -14'sd784,  -14'sd784,   14'sd1892, -14'sd1892,  14'sd784},
    '{ 14'sd400,  -14'sd1138,  14'sd1703, -14'sd2009,  14'sd2009, -14'sd1703,  14'sd1138, -14'sd400}
  };

  localparam logic signed [ACC_W:0] RND_HALF = (ACC_W+1)'(2**(FRAC-1));
  localparam logic signed [ACC_W:0] SAT_MAX  = (ACC_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN  = (ACC_W+1)'(-(2**(OUT_W-1)));

  // Round half up (add half, arithmetic shift = floor), then clamp to the output range.
  function automatic logic signed [OUT_W-1:0] sat_round(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W:0] w_sum;
    w_sum = (ACC_W+1)'(acc) + RND_HALF;
    w_sum = w_sum >>> FRAC;
    if (w_sum > SAT_MAX) begin
      return SAT_MAX[OUT_W-1:0];
    end else if (w_sum < SAT_MIN) begin
      return SAT_MIN[OUT_W-1:0];
    end
    return w_sum[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/idct_mac_lane.sv
// rtl/idct_mac_lane.sv - one output sample lane: multiply-accumulate over k, then round/saturate
// Lane LANE computes x[LANE] from the coefficient stream using column C[*][LANE].
module idct_mac_lane
  import idct_pkg::*;
#(
  parameter int LANE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_load,
  input  logic                     i_first,
  input  logic [2:0]               i_k,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic                     i_round,
  output logic signed [OUT_W-1:0]  o_y
);

  localparam int PROD_W = DATA_W + COS_W;
  localparam logic [2:0] LANE_IDX = 3'(LANE);

  logic signed [COS_W-1:0]  w_coef;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [OUT_W-1:0]  r_y;

  assign w_coef = COS_TAB[i_k][LANE_IDX];
  assign w_prod = PROD_W'(w_coef) * PROD_W'(i_data);

  // The k=0 beat overwrites the accumulator so blocks need no separate clear cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_y   <= '0;
    end else begin
      if (i_load) begin
        r_acc <= i_first ? ACC_W'(w_prod) : r_acc + ACC_W'(w_prod);
      end
      if (i_round) begin
        r_y <= sat_round(r_acc);
      end
    end
  end

  assign o_y = r_y;

endmodule

// File: rtl/idct8_1d_serial.sv
// rtl/idct8_1d_serial.sv - serial 8-point 1-D inverse DCT with valid/ready streams
// Eight MAC lanes accumulate in parallel; the FSM sequences load, round and drain phases.
module idct8_1d_serial
  import idct_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_last
);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_k_cnt, w_k_nxt;
  logic [2:0] r_n_cnt, w_n_nxt;
  logic       w_accept;
  logic       w_round;
  logic signed [OUT_W-1:0] w_y [8];

  for (genvar g = 0; g < 8; g++) begin : g_lane
    idct_mac_lane #(.LANE(g)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_accept),
      .i_first (r_k_cnt == 3'd0),
      .i_k     (r_k_cnt),
      .i_data  (in_data),
      .i_round (w_round),
      .o_y     (w_y[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_LOAD;
      r_k_cnt <= '0;
      r_n_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k_cnt <= w_k_nxt;
      r_n_cnt <= w_n_nxt;
    end
  end

  // Counters wrap naturally at 7 -> 0, ready for the next block.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k_cnt;
    w_n_nxt     = r_n_cnt;
    w_accept    = 1'b0;
    w_round     = 1'b0;
    case (r_state)
      ST_LOAD: begin
        if (in_valid) begin
          w_accept = 1'b1;
          w_k_nxt  = r_k_cnt + 3'd1;
          if (r_k_cnt == 3'd7) begin
            w_state_nxt = ST_ROUND;
          end
        end
      end
      ST_ROUND: begin
        w_round     = 1'b1;
        w_n_nxt     = 3'd0;
        w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (out_ready) begin
          w_n_nxt = r_n_cnt + 3'd1;
          if (r_n_cnt == 3'd7) begin
            w_state_nxt = ST_LOAD;
          end
        end
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  assign in_ready  = (r_state == ST_LOAD) && !rst;
  assign out_valid = (r_state == ST_DRAIN);
  assign out_data  = w_y[r_n_cnt];
  assign out_last  = (r_state == ST_DRAIN) && (r_n_cnt == 3'd7);

endmodule
